// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared types, constants and helpers for the MIPS fetch slice
//
// Contents:
//   WORD_W        datapath word width
//   NOP_WORD      word returned for fetches outside the instruction memory
//   fetch_state_e fetch run/halt state encoding
//   jump_target() j-type target concatenation
package mips_pkg;

  localparam int WORD_W = 32;

  localparam logic [WORD_W-1:0] NOP_WORD = 32'h0000_0000;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } fetch_state_e;

  // Region bits come from the incremented PC, so a jump stays inside the
  // 256 MB segment of the instruction that follows it.
  function automatic logic [WORD_W-1:0] jump_target(
    input logic [WORD_W-1:0] pc_plus4,
    input logic [25:0]       index
  );
    return {pc_plus4[31:28], index, 2'b00};
  endfunction

endpackage

// File: rtl/instr_rom.sv
// rtl/instr_rom.sv - asynchronous-read instruction memory with out-of-range NOP
//
// Parameters:
//   IMEM_WORDS  depth in 32-bit words (power of two)
//   INIT_FILE   name of the hex image the environment preloads into r_mem
// Ports:
//   i_addr  in  30  word address (byte address bits [31:2])
//   o_data  out 32  word at i_addr, NOP_WORD when i_addr >= IMEM_WORDS
module instr_rom
  import mips_pkg::*;
#(
  parameter int IMEM_WORDS = 256,
  parameter     INIT_FILE  = "program.hex"
) (
  input  logic [29:0]       i_addr,
  output logic [WORD_W-1:0] o_data
);

  localparam int AW = $clog2(IMEM_WORDS);

  logic [WORD_W-1:0] r_mem [IMEM_WORDS];
  logic              w_in_range;

  // Compare the full word address so aliasing above the array never occurs.
  assign w_in_range = (i_addr < 30'(IMEM_WORDS));
  assign o_data     = w_in_range ? r_mem[i_addr[AW-1:0]] : NOP_WORD;

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - single-cycle MIPS instruction fetch: PC, next-PC mux, run/halt FSM
//
// Optional feature macro: FETCH_PERF_CNT_EN (adds cycle_count / fetch_count).
//
// Parameters:
//   RESET_PC    PC loaded on reset
//   IMEM_WORDS  instruction memory depth in words (power of two)
//   INIT_FILE   instruction memory image name
//   HALT_WORD   sentinel instruction that stops fetch
// Ports:
//   clk          in   1   clock, rising edge
//   rst          in   1   synchronous reset, active low
//   stall        in   1   hold current PC this cycle
//   branch       in   1   beq-type instruction
//   zero         in   1   ALU zero flag
//   jump         in   1   j-type instruction
//   instruction  out  32  word at current PC (combinational)
//   pc           out  32  current program counter
//   pc_plus4     out  32  pc + 4 (combinational)
//   valid        out  1   current instruction executes this cycle
//   halted       out  1   fetch stopped on HALT_WORD
//   cycle_count  out  32  RUN cycles since reset (FETCH_PERF_CNT_EN only)
//   fetch_count  out  32  valid cycles since reset (FETCH_PERF_CNT_EN only)
module fetch_unit
  import mips_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC   = 32'h0000_0000,
  parameter int                IMEM_WORDS = 256,
  parameter                    INIT_FILE  = "program.hex",
  parameter logic [WORD_W-1:0] HALT_WORD  = 32'hFFFF_FFFF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              branch,
  input  logic              zero,
  input  logic              jump,
  output logic [WORD_W-1:0] instruction,
  output logic [WORD_W-1:0] pc,
  output logic [WORD_W-1:0] pc_plus4,
  output logic              valid,
  output logic              halted
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [WORD_W-1:0] cycle_count,
  output logic [WORD_W-1:0] fetch_count
`endif
);

  fetch_state_e      r_state;
  logic [WORD_W-1:0] r_pc;
  logic              r_halted;

  logic [WORD_W-1:0] w_branch_target;
  logic [WORD_W-1:0] w_next_pc;
  logic              w_is_halt;

  instr_rom #(
    .IMEM_WORDS (IMEM_WORDS),
    .INIT_FILE  (INIT_FILE)
  ) u_rom (
    .i_addr (r_pc[31:2]),
    .o_data (instruction)
  );

  assign pc        = r_pc;
  assign halted    = r_halted;
  assign pc_plus4  = r_pc + 32'd4;
  assign w_is_halt = (instruction == HALT_WORD);

  // valid folds together every hold condition (halted, stall, sentinel), so
  // branch/jump/zero only matter when it is high.
  assign valid = (r_state == RUN) && !stall && !w_is_halt;

  assign w_branch_target = pc_plus4 + {{14{instruction[15]}}, instruction[15:0], 2'b00};

  always_comb begin
    w_next_pc = pc_plus4;
    if (!valid) begin
      w_next_pc = r_pc;
    end else if (jump) begin
      w_next_pc = jump_target(pc_plus4, instruction[25:0]);
    end else if (branch && zero) begin
      w_next_pc = w_branch_target;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [WORD_W-1:0] r_cycle_count;
  logic [WORD_W-1:0] r_fetch_count;

  assign cycle_count = r_cycle_count;
  assign fetch_count = r_fetch_count;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_pc     <= RESET_PC;
      r_state  <= RUN;
      r_halted <= 1'b0;
`ifdef FETCH_PERF_CNT_EN
      r_cycle_count <= '0;
      r_fetch_count <= '0;
`endif
    end else begin
      r_pc <= w_next_pc;
      case (r_state)
        RUN: begin
          if (w_is_halt && !stall) begin
            r_state  <= HALTED;
            r_halted <= 1'b1;
          end
        end
        HALTED: begin
          r_state  <= HALTED;
          r_halted <= 1'b1;
        end
        default: begin
          r_state  <= RUN;
          r_halted <= 1'b0;
        end
      endcase
`ifdef FETCH_PERF_CNT_EN
      // Both counters stop in HALTED: valid is already low there.
      if (r_state == RUN) begin
        r_cycle_count <= r_cycle_count + 32'd1;
      end
      if (valid) begin
        r_fetch_count <= r_fetch_count + 32'd1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - scoreboard testbench for fetch_unit
module tb_fetch_unit;

  localparam logic [31:0] FILL = 32'h0000_0020;
  localparam logic [31:0] HALT = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0;
  logic        branch = 1'b0;
  logic        zero = 1'b0;
  logic        jump = 1'b0;
  logic [31:0] instruction;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        valid;
  logic        halted;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] cycle_count;
  logic [31:0] fetch_count;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          id;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        v;
    logic        h;
    logic        cnt;
    logic [31:0] cc;
    logic [31:0] fc;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  fetch_unit #(
    .RESET_PC   (32'h0000_0040),
    .IMEM_WORDS (64),
    .INIT_FILE  ("program.hex"),
    .HALT_WORD  (HALT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .branch      (branch),
    .zero        (zero),
    .jump        (jump),
    .instruction (instruction),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .valid       (valid),
    .halted      (halted)
`ifdef FETCH_PERF_CNT_EN
    ,
    .cycle_count (cycle_count),
    .fetch_count (fetch_count)
`endif
  );

  task automatic chk(input string name, input int id, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s step%0d actual=%h required=%h", name, id, act, req);
    end
  endtask

  // One clock: inputs driven here apply during the cycle whose state
  // (pc/instruction/valid/halted) the pushed record describes.
  task automatic cyc(input int id, input logic r, input logic s, input logic b,
                     input logic z, input logic j, input logic [31:0] epc,
                     input logic [31:0] einstr, input logic ev, input logic eh,
                     input logic ecnt = 1'b0, input logic [31:0] ecc = 32'd0,
                     input logic [31:0] efc = 32'd0);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; stall = s; branch = b; zero = z; jump = j;
    e.id = id; e.pc = epc; e.instr = einstr; e.v = ev; e.h = eh;
    e.cnt = ecnt; e.cc = ecc; e.fc = efc;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    if (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("pc", e.id, pc, e.pc);
      chk("instruction", e.id, instruction, e.instr);
      chk("pc_plus4", e.id, pc_plus4, e.pc + 32'd4);
      chk("valid", e.id, {31'd0, valid}, {31'd0, e.v});
      chk("halted", e.id, {31'd0, halted}, {31'd0, e.h});
`ifdef FETCH_PERF_CNT_EN
      if (e.cnt) begin
        chk("cycle_count", e.id, cycle_count, e.cc);
        chk("fetch_count", e.id, fetch_count, e.fc);
      end
`endif
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 64; i++) dut.u_rom.r_mem[i] = FILL;
    dut.u_rom.r_mem[0]  = 32'h0800_0008;  // 0x00: j 0x20
    dut.u_rom.r_mem[1]  = 32'h0800_0002;  // 0x04: j 0x08
    dut.u_rom.r_mem[2]  = 32'h1000_FFFE;  // 0x08: beq imm -2
    dut.u_rom.r_mem[3]  = 32'h0800_0004;  // 0x0C: j 0x10
    dut.u_rom.r_mem[4]  = 32'h0800_0040;  // 0x10: j 0x100 (out of range)
    dut.u_rom.r_mem[5]  = HALT;           // 0x14
    dut.u_rom.r_mem[9]  = 32'h0800_0005;  // 0x24: j 0x14
    dut.u_rom.r_mem[18] = 32'h0800_0002;  // 0x48: j 0x08
    dut.u_rom.r_mem[21] = HALT;           // 0x54

    // reset held two edges, then sequential fetch
    cyc(1,  0, 0, 0, 0, 0, 32'h40,  FILL,          1, 0, 1, 0, 0);
    cyc(2,  1, 0, 0, 0, 0, 32'h40,  FILL,          1, 0);
    cyc(3,  1, 0, 0, 0, 0, 32'h44,  FILL,          1, 0);
    cyc(4,  1, 0, 0, 0, 1, 32'h48,  32'h0800_0002, 1, 0);
    // taken branch backwards, then not-taken
    cyc(5,  1, 0, 1, 1, 0, 32'h08,  32'h1000_FFFE, 1, 0);
    cyc(6,  1, 0, 0, 0, 1, 32'h04,  32'h0800_0002, 1, 0);
    cyc(7,  1, 0, 1, 0, 0, 32'h08,  32'h1000_FFFE, 1, 0);
    cyc(8,  1, 0, 0, 0, 1, 32'h0C,  32'h0800_0004, 1, 0);
    // jump wins over a taken branch
    cyc(9,  1, 0, 1, 1, 1, 32'h10,  32'h0800_0040, 1, 0);
    // beyond memory reads NOP; jump with index 0 goes to 0
    cyc(10, 1, 0, 0, 0, 1, 32'h100, 32'h0,         1, 0);
    cyc(11, 1, 0, 0, 0, 1, 32'h00,  32'h0800_0008, 1, 0);
    // stall three cycles with jump asserted: ignored
    cyc(12, 1, 1, 0, 0, 1, 32'h20,  FILL,          0, 0);
    cyc(13, 1, 1, 0, 0, 1, 32'h20,  FILL,          0, 0);
    cyc(14, 1, 1, 0, 0, 1, 32'h20,  FILL,          0, 0);
    cyc(15, 1, 0, 0, 0, 0, 32'h20,  FILL,          1, 0);
    cyc(16, 1, 0, 0, 0, 1, 32'h24,  32'h0800_0005, 1, 0);
    // halt sentinel: controls ignored, pc sticks
    cyc(17, 1, 0, 1, 1, 1, 32'h14,  HALT,          0, 0);
    cyc(18, 1, 0, 0, 0, 1, 32'h14,  HALT,          0, 1);
    cyc(19, 1, 1, 0, 0, 1, 32'h14,  HALT,          0, 1);
    cyc(20, 0, 0, 0, 0, 0, 32'h14,  HALT,          0, 1);
    // reset leaves HALTED
    cyc(21, 0, 0, 0, 0, 0, 32'h40,  FILL,          1, 0);
    // five fetches, one stall, halt at 0x54; counters frozen afterwards
    cyc(22, 1, 0, 0, 0, 0, 32'h40,  FILL,          1, 0, 1, 0, 0);
    cyc(23, 1, 0, 0, 0, 0, 32'h44,  FILL,          1, 0);
    cyc(24, 1, 0, 0, 0, 0, 32'h48,  32'h0800_0002, 1, 0);
    cyc(25, 1, 1, 0, 0, 0, 32'h4C,  FILL,          0, 0);
    cyc(26, 1, 0, 0, 0, 0, 32'h4C,  FILL,          1, 0);
    cyc(27, 1, 0, 0, 0, 0, 32'h50,  FILL,          1, 0);
    cyc(28, 1, 0, 0, 0, 0, 32'h54,  HALT,          0, 0);
    cyc(29, 1, 0, 0, 0, 0, 32'h54,  HALT,          0, 1, 1, 7, 5);
    cyc(30, 1, 0, 0, 0, 0, 32'h54,  HALT,          0, 1, 1, 7, 5);

    for (int k = 0; k < 10 && sb.size() != 0; k++) @(posedge clk);
    if (sb.size() != 0) begin
      errors++;
      checks++;
      $display("FAIL drain pending=%0d required=0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the single-cycle MIPS core. It holds the program counter, reads the instruction memory, and computes the next PC from the branch/jump controls. It drives `instruction` into the control unit, register-file address decode and immediate extender. It also owns a small run/halt state machine so benches can stop the core cleanly on a sentinel word.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- IMEM_WORDS, 256, instruction memory depth in 32-bit words (power of two)
- INIT_FILE, "program.hex", hex image loaded into instruction memory at elaboration
- HALT_WORD, 32'hFFFF_FFFF, sentinel instruction that halts fetch

Ports:
- clk  in  1  single clock; all state changes on the rising edge
- rst  in  1  synchronous, active-low reset: sampled on rising clk, 0 = reset
- stall  in  1  hold current PC this cycle
- branch  in  1  from control unit: beq-type instruction
- zero  in  1  from ALU zero flag
- jump  in  1  from control unit: j-type instruction
- instruction  out  32  word at current PC, combinational from pc
- pc  out  32  current program counter
- pc_plus4  out  32  pc + 4, combinational
- valid  out  1  current instruction executes this cycle
- halted  out  1  fetch stopped on HALT_WORD

## Operation
- Memory read is asynchronous: instruction = mem[pc[log2(IMEM_WORDS)+1:2]].
- pc >= 4*IMEM_WORDS reads 32'h0000_0000 (nop). pc[1:0] are ignored.
- Branch target = pc_plus4 + (signext(instruction[15:0]) << 2), in 32-bit wrap-around arithmetic.
- Jump target = {pc_plus4[31:28], instruction[25:0], 2'b00}.
- States: RUN, HALTED. Reset enters RUN.
  - RUN -> HALTED when instruction == HALT_WORD and stall == 0.
  - HALTED exits only via reset.
- valid = (state == RUN) && !stall && (instruction != HALT_WORD).
- Next-PC priority, highest first:
  - reset -> RESET_PC
  - HALTED -> hold
  - stall -> hold
  - instruction == HALT_WORD -> hold
  - jump -> jump target
  - branch && zero -> branch target
  - otherwise -> pc_plus4
- jump and branch asserted together: jump wins.
- branch with zero == 0 falls through to pc_plus4.
- pc + 4 from 32'hFFFF_FFFC wraps to 0.
- branch/jump/zero are ignored whenever valid == 0.

## Timing
- Reset values: pc = RESET_PC, halted = 0, state RUN. valid then follows its combinational rule. Counters reset to 0 (see Configuration).
- Reset mid-operation overrides stall and HALTED in the same edge.
- Latency: next PC is visible one cycle after the instruction that selected it. Zero delay slots.
- instruction, pc_plus4 and valid are combinational from registered pc/state plus the stall input. No handshake beyond stall.
- halted rises in the cycle after HALT_WORD is fetched with stall low, and stays high.

## Configuration
- FETCH_PERF_CNT_EN defined: adds outputs cycle_count[31:0] and fetch_count[31:0].
  - cycle_count increments every non-reset cycle while state == RUN.
  - fetch_count increments on every cycle with valid == 1.
  - Both reset to 0, wrap modulo 2^32, and freeze in HALTED.
- Undefined: both ports and counters are absent. All other behaviour is identical.

## Structure
- Shared package mips_pkg:
  - WORD_W = 32
  - fetch state enum (RUN, HALTED)
  - NOP_WORD = 32'h0
  - helper function for jump-target concatenation
- One sub-module, instr_rom: parameters IMEM_WORDS, INIT_FILE; async read; word-address in, 32-bit data out; returns NOP_WORD out of range.
- PC register, next-PC mux, state machine and counters stay in fetch_unit.

## Test plan
- Reset: hold rst = 0 for 2 cycles with RESET_PC = 32'h40 -> pc = 32'h40, halted = 0. After release, pc steps 40, 44, 48.
- Branch: instruction at 8 is beq with imm = 16'hFFFE, branch = 1, zero = 1 -> next pc = 8 + 4 - 8 = 32'h4. With zero = 0 -> next pc = 32'hC.
- Jump:
  - pc = 32'h10, instr[25:0] = 26'h000_0040, jump = 1 -> next pc = 32'h100.
  - Same cycle with branch = 1, zero = 1 -> pc still 32'h100.
- Stall: stall = 1 for 3 cycles at pc = 32'h20 -> pc stays 32'h20, valid = 0, jump ignored. On release pc -> 32'h24.
- Halt: HALT_WORD at 32'h14 ->
  - pc sticks at 32'h14, halted = 1 from the next cycle, valid = 0 forever.
  - Driving rst = 0 returns pc to RESET_PC, halted = 0.
- Perf (FETCH_PERF_CNT_EN): 5 sequential instructions, one stall cycle, then HALT_WORD -> fetch_count = 5, cycle_count = 7, both frozen after halt.
